uart_cmd_sequencer: RTL
=======================

// Module: uart_cmd_sequencer
// PURPOSE
//  Sequences the uart block for a command/response link (ELM327-style): streams one CR-terminated
//  command from an external command ROM into the TX FIFO, collects reply bytes from the RX FIFO into
//  an internal buffer until the '>' prompt, and reports length/status. Sits between top-level logic and uart.
// PARAMETERS
//  CMD_AW    5    command ROM address bits
//  RSP_AW    5    response buffer address bits (depth 2**RSP_AW)
//  TO_BITS   24   response timeout counter width
//  MAX_CMD   32   max bytes sent per command without CR before abort
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        asynchronous, active-low reset
//  start       in   1        1-cycle pulse: run command at cmd_base (ignored while busy)
//  cmd_base    in   CMD_AW   ROM start address of command
//  to_limit    in   TO_BITS  idle-RX clk cycles before timeout
//  rom_addr    out  CMD_AW   command ROM address
//  rom_data    in   8        ROM data, valid 1 cycle after rom_addr
//  wr_uart     out  1        to uart (edge-triggered), w_data out 8 byte to send
//  tx_full     in   1        uart TX FIFO full
//  rd_uart     out  1        to uart (edge-triggered); r_data in 8 RX FIFO head
//  rx_empty    in   1        uart RX FIFO empty
//  e_parity, e_frame, e_rxof, e_txof  in  1 each  uart error flags
//  rsp_raddr   in   RSP_AW   response buffer read address; rsp_rdata out 8, registered, 1-cycle latency
//  rsp_len     out  RSP_AW+1 bytes stored for last response
//  busy        out  1        high from start accept to done
//  done        out  1        1-cycle pulse at end of every run (success or abort)
//  status      out  5        {timeout, cmd_err, line_err, rsp_ovf, fifo_of}, valid at done, held to next start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rsp_len 0. reset_n low mid-run aborts immediately, no done.
//  uart strobes are edge-triggered: wr_uart/rd_uart high exactly 1 cycle, then >=2 low cycles before
//   next strobe or re-sampling tx_full/rx_empty (uart FIFO updates one cycle after the edge).
//  States: IDLE -> FLUSH -> FETCH -> SEND -> SEND_GAP -> (FETCH | RECV) ; RECV -> RECV_GAP -> RECV;
//   RECV/SEND -> FIN -> IDLE.
//  IDLE: start latches cmd_base to rom_addr, clears status, rsp_len=0, busy=1.
//  FLUSH: while !rx_empty pop and discard bytes (stale replies); when rx_empty go FETCH.
//  FETCH: wait 1 cycle for rom_data. SEND: when !tx_full, w_data<=rom_data, wr_uart pulse, count++.
//   SEND_GAP (2 cycles): if byte==8'h0D go RECV, else rom_addr+1 (wraps mod 2**CMD_AW) -> FETCH.
//   Count reaching MAX_CMD without CR: cmd_err=1 -> FIN.
//  RECV: timeout counter cleared on entry and per byte; if !rx_empty: byte 8'h3E -> pop, FIN (not stored);
//   else store at rsp_len if rsp_len < 2**RSP_AW (else drop, rsp_ovf=1), pop, RECV_GAP (2 cycles).
//   8'h0D/8'h0A are stored. Counter == to_limit (to_limit 0 = no timeout): timeout=1 -> FIN.
//  line_err/fifo_of: sticky OR of e_parity|e_frame / e_rxof|e_txof sampled every cycle while busy;
//   they do not abort.
//  FIN: done=1, busy=0 same cycle; next cycle IDLE. start coincident with done is ignored.
//  rsp_rdata readable any time; writes and reads same address same cycle return old data.
// STRUCTURE
//  Shared include uart_defs.vh: CHR_CR=8'h0D, CHR_PROMPT=8'h3E, state localparams, status bit indices.
//  One sub-module: rsp_buffer (simple dual-port sync RAM, 8 x 2**RSP_AW). FSM + counters in this file.
// TESTING (bench pairs with uart loopback model or BFM on FIFO ports)
//  ROM "ATZ\r" at 0, reply "ELM327\r\r>" -> 4 wr_uart pulses ≥3 cycles apart, rsp_len=8, status=0, one done.
//  Reply 40 bytes + '>' with RSP_AW=5 -> rsp_len=32, first 32 bytes stored, rsp_ovf=1, done.
//  No reply, to_limit=1000 -> done exactly 1000 cycles after last SEND_GAP exit (+FIN), timeout=1.
//  ROM 40 bytes without 0x0D -> 32 wr_uart pulses, cmd_err=1, no RECV entry.
//  3 stale bytes in RX FIFO at start -> 3 discard pops before first wr_uart; tx_full held 50 cycles -> send stalls.
//  reset_n low during RECV -> busy=0, done never pulses, outputs 0; e_frame pulse in RECV -> line_err=1.

Source files
------------

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants, FSM state type and status bit positions
// for the uart command/response sequencer.
package uart_cmd_sequencer_pkg;

    localparam logic [7:0] CHR_CR     = 8'h0D;
    localparam logic [7:0] CHR_PROMPT = 8'h3E;

    // Bit positions inside the 5-bit status word.
    localparam int ST_TIMEOUT  = 4;
    localparam int ST_CMD_ERR  = 3;
    localparam int ST_LINE_ERR = 2;
    localparam int ST_RSP_OVF  = 1;
    localparam int ST_FIFO_OF  = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_FLUSH_GAP,
        S_FETCH,
        S_SEND,
        S_SEND_GAP,
        S_RECV,
        S_RECV_GAP,
        S_FIN
    } state_t;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// FIFO-side connection between the sequencer and the uart block.
// master: sequencer (drives strobes/w_data); slave: uart.
interface uart_cmd_sequencer_if;

    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full;
    logic       rd_uart;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       e_parity;
    logic       e_frame;
    logic       e_rxof;
    logic       e_txof;

    modport master (
        output wr_uart, w_data, rd_uart,
        input  tx_full, r_data, rx_empty,
        input  e_parity, e_frame, e_rxof, e_txof
    );

    modport slave (
        input  wr_uart, w_data, rd_uart,
        output tx_full, r_data, rx_empty,
        output e_parity, e_frame, e_rxof, e_txof
    );

endinterface

// File: rtl/uart_cmd_sequencer_rsp_buffer.sv
// Response buffer: simple dual-port sync RAM, 8 x 2**AW.
// Ports: i_we/i_waddr/i_wdata write; i_raddr -> o_rdata (1-cycle).
module uart_cmd_sequencer_rsp_buffer #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking read: same-address write returns old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Streams one CR-terminated command from ROM to the uart TX FIFO,
// collects the reply up to the '>' prompt and reports len/status.
// Ports: clk, reset_n; i_start/i_cmd_base/i_to_limit run control;
// o_rom_addr/i_rom_data ROM; uart (FIFO side, master);
// i_rsp_raddr/o_rsp_rdata buffer read; o_rsp_len, o_busy,
// o_done, o_status {timeout,cmd_err,line_err,rsp_ovf,fifo_of}.
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int CMD_AW  = 5,
    parameter int RSP_AW  = 5,
    parameter int TO_BITS = 24,
    parameter int MAX_CMD = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic [CMD_AW-1:0]   i_cmd_base,
    input  logic [TO_BITS-1:0]  i_to_limit,
    output logic [CMD_AW-1:0]   o_rom_addr,
    input  logic [7:0]          i_rom_data,
    uart_cmd_sequencer_if.master uart,
    input  logic [RSP_AW-1:0]   i_rsp_raddr,
    output logic [7:0]          o_rsp_rdata,
    output logic [RSP_AW:0]     o_rsp_len,
    output logic                o_busy,
    output logic                o_done,
    output logic [4:0]          o_status
);

    localparam int CW = $clog2(MAX_CMD + 1);
    localparam logic [CW-1:0] CMD_LIM = CW'(MAX_CMD);
    localparam logic [RSP_AW:0] RSP_DEPTH = {1'b1, {RSP_AW{1'b0}}};

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_gap;
    logic                w_gap_nx;
    logic [CMD_AW-1:0]   r_rom_addr;
    logic [CMD_AW-1:0]   w_rom_addr_nx;
    logic [7:0]          r_w_data;
    logic [7:0]          w_w_data_nx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
    logic [TO_BITS-1:0]  r_to;
    logic [TO_BITS-1:0]  w_to_nx;
    logic [TO_BITS-1:0]  w_to_inc;
    logic [RSP_AW:0]     r_len;
    logic [RSP_AW:0]     w_len_nx;
    logic [4:0]          r_status;
    logic [4:0]          w_status_nx;
    logic                w_busy;
    logic                w_wr;
    logic                w_rd;
    logic                w_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gap      <= 1'b0;
            r_rom_addr <= '0;
            r_w_data   <= '0;
            r_cnt      <= '0;
            r_to       <= '0;
            r_len      <= '0;
            r_status   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_gap      <= w_gap_nx;
            r_rom_addr <= w_rom_addr_nx;
            r_w_data   <= w_w_data_nx;
            r_cnt      <= w_cnt_nx;
            r_to       <= w_to_nx;
            r_len      <= w_len_nx;
            r_status   <= w_status_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_gap_nx      = r_gap;
        w_rom_addr_nx = r_rom_addr;
        w_w_data_nx   = r_w_data;
        w_cnt_nx      = r_cnt;
        w_to_nx       = r_to;
        w_len_nx      = r_len;
        w_status_nx   = r_status;
        w_wr          = 1'b0;
        w_rd          = 1'b0;
        w_we          = 1'b0;
        w_to_inc      = r_to + 1'b1;
        w_busy        = (r_state != S_IDLE) && (r_state != S_FIN);

        // uart error flags accumulate but never abort the run.
        if (w_busy) begin
            w_status_nx[ST_LINE_ERR] = r_status[ST_LINE_ERR]
                                     | uart.e_parity | uart.e_frame;
            w_status_nx[ST_FIFO_OF]  = r_status[ST_FIFO_OF]
                                     | uart.e_rxof | uart.e_txof;
        end

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_rom_addr_nx = i_cmd_base;
                    w_status_nx   = '0;
                    w_len_nx      = '0;
                    w_cnt_nx      = '0;
                    w_state_nx    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!uart.rx_empty) begin
                    w_rd       = 1'b1;
                    w_gap_nx   = 1'b0;
                    w_state_nx = S_FLUSH_GAP;
                end else begin
                    w_state_nx = S_FETCH;
                end
            end
            S_FLUSH_GAP: begin
                if (r_gap) begin
                    w_state_nx = S_FLUSH;
                end else begin
                    w_gap_nx = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_nx = S_SEND;
            end
            S_SEND: begin
                if (!uart.tx_full) begin
                    w_w_data_nx = i_rom_data;
                    w_cnt_nx    = r_cnt + 1'b1;
                    w_gap_nx    = 1'b0;
                    w_state_nx  = S_SEND_GAP;
                end
            end
            S_SEND_GAP: begin
                // w_data is registered in SEND, so the strobe
                // lands on the first gap cycle.
                w_wr = !r_gap;
                if (r_gap) begin
                    if (r_w_data == CHR_CR) begin
                        w_to_nx    = '0;
                        w_state_nx = S_RECV;
                    end else if (r_cnt == CMD_LIM) begin
                        w_status_nx[ST_CMD_ERR] = 1'b1;
                        w_state_nx = S_FIN;
                    end else begin
                        w_rom_addr_nx = r_rom_addr + 1'b1;
                        w_state_nx    = S_FETCH;
                    end
                end else begin
                    w_gap_nx = 1'b1;
                end
            end
            S_RECV: begin
                if (!uart.rx_empty) begin
                    w_rd    = 1'b1;
                    w_to_nx = '0;
                    if (uart.r_data == CHR_PROMPT) begin
                        w_state_nx = S_FIN;
                    end else begin
                        if (r_len < RSP_DEPTH) begin
                            w_we     = 1'b1;
                            w_len_nx = r_len + 1'b1;
                        end else begin
                            w_status_nx[ST_RSP_OVF] = 1'b1;
                        end
                        w_gap_nx   = 1'b0;
                        w_state_nx = S_RECV_GAP;
                    end
                end else if ((i_to_limit != '0)
                             && (w_to_inc == i_to_limit)) begin
                    w_status_nx[ST_TIMEOUT] = 1'b1;
                    w_state_nx = S_FIN;
                end else begin
                    w_to_nx = w_to_inc;
                end
            end
            S_RECV_GAP: begin
                if (r_gap) begin
                    w_state_nx = S_RECV;
                end else begin
                    w_gap_nx = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    uart_cmd_sequencer_rsp_buffer #(
        .AW (RSP_AW)
    ) u_rsp_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_waddr (r_len[RSP_AW-1:0]),
        .i_wdata (uart.r_data),
        .i_raddr (i_rsp_raddr),
        .o_rdata (o_rsp_rdata)
    );

    assign uart.wr_uart = w_wr;
    assign uart.rd_uart = w_rd;
    assign uart.w_data  = r_w_data;
    assign o_rom_addr   = r_rom_addr;
    assign o_rsp_len    = r_len;
    assign o_busy       = w_busy;
    assign o_done       = (r_state == S_FIN);
    assign o_status     = r_status;

endmodule
